// File: rtl/serial_shift_unit_if.sv
// Start/busy/done bundle between the ALU sequencer and the serial shifter.
// master = sequencer side, slave = shift unit side.
interface serial_shift_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       ctrl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, a, b, ctrl,
    input  busy, done, result
  );

  modport slave (
    input  start, a, b, ctrl,
    output busy, done, result
  );
endinterface

// File: rtl/serial_shift_unit.sv
// Multi-cycle shifter: STEP bits per cycle until b[SHAMT_W-1:0] is consumed.
// Define SHIFT_ROTATE_EN to make ctrl=01 rotate-left instead of SLL.
module serial_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic clk,
  input  logic rst_n,
  serial_shift_unit_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [SHAMT_W:0] STEP_V  = (SHAMT_W+1)'(STEP);
  localparam logic [SHAMT_W:0] WIDTH_V = (SHAMT_W+1)'(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] res;
  logic [SHAMT_W:0] rem;
  logic [1:0]       mode;

  logic [SHAMT_W:0] amt;
  logic [SHAMT_W:0] step;
  logic             last;
  logic [WIDTH-1:0] shifted;
  logic             is_sra;
  logic             is_srl;
  logic             unused_b;

  assign amt      = {1'b0, bus.b[SHAMT_W-1:0]};
  assign unused_b = ^bus.b[WIDTH-1:SHAMT_W];

  assign step = (rem < STEP_V) ? rem : STEP_V;
  assign last = (rem <= STEP_V);

  assign is_sra = (mode == 2'b10);
  assign is_srl = (mode == 2'b11);

`ifdef SHIFT_ROTATE_EN
  logic             is_rol;
  logic [SHAMT_W:0] rot_amt;

  assign is_rol  = (mode == 2'b01);
  assign rot_amt = WIDTH_V - step;

  always_comb begin
    shifted = work << step;
    unique case (1'b1)
      is_sra:  shifted = $signed(work) >>> step;
      is_srl:  shifted = work >> step;
      is_rol:  shifted = (work << step) | (work >> rot_amt);
      default: shifted = work << step;
    endcase
  end
`else
  logic unused_w;
  assign unused_w = ^WIDTH_V;

  // ctrl=01 deliberately falls into the SLL default
  always_comb begin
    shifted = work << step;
    unique case (1'b1)
      is_sra:  shifted = $signed(work) >>> step;
      is_srl:  shifted = work >> step;
      default: shifted = work << step;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      res   <= '0;
      rem   <= '0;
      mode  <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            work <= bus.a;
            mode <= bus.ctrl;
            rem  <= amt;
            if (amt == '0) begin
              res   <= bus.a;
              state <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          work <= shifted;
          rem  <= rem - step;
          // final step lands in result on the same edge
          if (last) begin
            res   <= shifted;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = res;

endmodule
